// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
// Places N bus masters on one single-port shared memory. Only one transaction
// is in flight at a time. The grant is round-robin by default. Each master gets
// a one-cycle m_ready pulse when its transaction completes.
//
// Ports
//   clock, reset           rising-edge clock; synchronous active-high reset
//   m_lerMem / m_escMem    per-master read / write request (write wins if both)
//   m_endereco / m_indata  per-master address / write data, master i at [i*W +: W]
//   m_ready                one-cycle completion pulse to the granted master
//   m_rdata                read data, valid in the m_ready cycle of a read
//   endereco / indata      address / write data to the memory
//   lerMem / escMem        one-cycle memory read / write strobes
//   output_mem             memory read data, valid MEM_LAT cycles after lerMem
//
// Build option: define ARB_FIXED_PRIO_EN to grant the lowest-index requester
// instead of round-robin (rr_ptr is then held at 0).
//
// state | meaning
// IDLE  | arbitrate pending requests, capture grant and operands
// ISSUE | drive lerMem or escMem for exactly one cycle
// WAIT  | count down the remaining memory read latency
// DONE  | pulse m_ready to the granted master, advance rr_ptr

module shared_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_lerMem,
  input  logic [N_MASTERS-1:0]          m_escMem,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_endereco,
  input  logic [N_MASTERS*DATA_W-1:0]   m_indata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             endereco,
  output logic [DATA_W-1:0]             indata,
  output logic                          lerMem,
  output logic                          escMem,
  input  logic [DATA_W-1:0]             output_mem
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick;
  logic                 pick_valid;
  logic                 wr_op;
  logic                 capture;
  logic [CNT_W-1:0]     cnt;
  logic [N_MASTERS-1:0] req;

  assign req = m_lerMem | m_escMem;

  // Arbitration: choose the requester that IDLE would grant this cycle.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
`ifdef ARB_FIXED_PRIO_EN
    // Walk downward so the lowest index is the last one written.
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick_valid = 1'b1;
        pick       = IDX_W'(k);
      end
    end
`else
    begin
      logic [IDX_W:0] slot;
      slot = '0;
      // Search upward from rr_ptr, wrapping past N_MASTERS-1 back to 0.
      for (int k = 0; k < N_MASTERS; k++) begin
        slot = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (slot >= (IDX_W + 1)'(N_MASTERS)) begin
          slot = slot - (IDX_W + 1)'(N_MASTERS);
        end
        if (!pick_valid && req[slot[IDX_W-1:0]]) begin
          pick_valid = 1'b1;
          pick       = slot[IDX_W-1:0];
        end
      end
    end
`endif
  end

  // Next state and memory-side strobes.
  always_comb begin
    state_next = state;
    lerMem     = 1'b0;
    escMem     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = ISSUE;
      end
      ISSUE: begin
        lerMem = ~wr_op;
        escMem = wr_op;
        if (wr_op) begin
          state_next = DONE;
        end else if (MEM_LAT == 1) begin
          state_next = DONE;
          capture    = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_ready = '0;
    if (state == DONE) m_ready[grant] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      wr_op    <= 1'b0;
      cnt      <= '0;
      endereco <= '0;
      indata   <= '0;
      m_rdata  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick;
            wr_op    <= m_escMem[pick];
            endereco <= m_endereco[int'(pick) * ADDR_W +: ADDR_W];
            indata   <= m_indata[int'(pick) * DATA_W +: DATA_W];
          end
        end
        ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
`ifdef ARB_FIXED_PRIO_EN
          rr_ptr <= '0;
`else
          rr_ptr <= (grant == IDX_W'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
`endif
        end
        default: ;
      endcase
      // Sampled on the edge that enters DONE, so it is stable for the m_ready cycle.
      if (capture) m_rdata <= output_mem;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter (3 masters, 32-bit, MEM_LAT=3).
// A directed vector table plus hand-written multi-cycle sequences. A queue
// scoreboard holds the expected transactions, and a memory model with real
// read latency returns the read data.
module tb_shared_mem_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_lerMem, m_escMem;
  logic [NM*AW-1:0]  m_endereco;
  logic [NM*DW-1:0]  m_indata;
  logic [NM-1:0]     m_ready;
  logic [DW-1:0]     m_rdata, indata, output_mem;
  logic [AW-1:0]     endereco;
  logic              lerMem, escMem;

  shared_mem_arbiter #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
    .clock(clock), .reset(reset),
    .m_lerMem(m_lerMem), .m_escMem(m_escMem),
    .m_endereco(m_endereco), .m_indata(m_indata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .endereco(endereco), .indata(indata),
    .lerMem(lerMem), .escMem(escMem),
    .output_mem(output_mem)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int ready_total = 0;
  int rr_model = 0;
  logic [31:0] last_rd = '0;

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          m;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[9];

  logic [31:0] shadow[logic [31:0]];
  logic [31:0] mem[logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: write on escMem edge; read data valid only ML cycles after lerMem.
  logic        rd_active = 1'b0;
  logic [2:0]  rd_cnt = '0;
  logic [31:0] rd_data = '0;
  assign output_mem = (rd_active && rd_cnt == 3'd0) ? rd_data : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (escMem) mem[endereco] = indata;
    if (lerMem) begin
      rd_active <= 1'b1;
      rd_cnt    <= 3'(ML - 1);
      rd_data   <= mem.exists(endereco) ? mem[endereco] : init_val(endereco);
    end else if (rd_active) begin
      if (rd_cnt == 3'd0) rd_active <= 1'b0;
      else rd_cnt <= rd_cnt - 3'd1;
    end
  end

  // Monitor: strobes are checked against the head of the queue, and m_ready pops it.
  always @(negedge clock) begin
    if (!reset) begin
      if (lerMem || escMem) begin
        strobes++;
        check("strobe_excl", 64'(lerMem & escMem), 64'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected actual=strobe required=none");
        end else begin
          check("strobe_is_write", 64'(escMem), 64'(sb[0].wr));
          check("mem_addr", 64'(endereco), 64'(sb[0].addr));
          if (sb[0].wr) check("mem_wdata", 64'(indata), 64'(sb[0].data));
        end
      end
      if (m_ready != '0) begin
        ready_total++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL ready_unexpected actual=%0h required=0", m_ready);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_grant", 64'(m_ready), 64'(1) << e.m);
          if (!e.wr) check("rdata", 64'(m_rdata), 64'(e.rdata));
        end
      end
    end
  end

  function automatic int model_pick(input logic [NM-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NM; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (rr_model + k) % NM;
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  function automatic void advance_rr(input int g);
`ifdef ARB_FIXED_PRIO_EN
    rr_model = 0;
`else
    rr_model = (g + 1) % NM;
`endif
  endfunction

  function automatic logic [31:0] push_exp(input int m, input bit wr,
                                           input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = a; e.data = d;
    e.rdata = shadow.exists(a) ? shadow[a] : init_val(a);
    if (wr) shadow[a] = d;
    sb.push_back(e);
    advance_rr(m);
    return e.rdata;
  endfunction

  task automatic wait_ready(input int m, input int budget, output int edges, output bit seen);
    edges = 0;
    seen = 1'b0;
    while (!seen && edges < budget) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (m_ready[m]) seen = 1'b1;
    end
  endtask

  // One transaction from a lone master. Starts just after a rising edge, with the DUT in IDLE.
  task automatic do_txn(input int m, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    int edges, s0;
    bit seen;
    logic [31:0] exp_rd;
    exp_rd = push_exp(m, wr, a, d);
    s0 = strobes;
    m_endereco[m*AW +: AW] = a;
    m_indata[m*DW +: DW]   = d;
    m_lerMem[m] = rd;
    m_escMem[m] = wr;
    wait_ready(m, 20, edges, seen);
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(edges), wr ? 64'd2 : 64'(ML + 2));
    check("strobe_count", 64'(strobes - s0), 64'd1);
    if (wr) check("rdata_hold", 64'(m_rdata), 64'(last_rd));
    else last_rd = exp_rd;
    m_lerMem[m] = 1'b0;
    m_escMem[m] = 1'b0;
    @(posedge clock); #1;
    check("addr_hold", 64'(endereco), 64'(a));
    check("wdata_hold", 64'(indata), 64'(d));
  endtask

  // All masters in mask hold write requests until count completions are seen.
  task automatic run_burst(input logic [NM-1:0] mask, input int count);
    int n, budget;
    for (int k = 0; k < count; k++) begin
      int g;
      g = model_pick(mask);
      void'(push_exp(g, 1'b1, 32'h100 + 32'(4 * g), 32'hB0B0_0000 + 32'(g)));
    end
    for (int i = 0; i < NM; i++) begin
      if (mask[i]) begin
        m_endereco[i*AW +: AW] = 32'h100 + 32'(4 * i);
        m_indata[i*DW +: DW]   = 32'hB0B0_0000 + 32'(i);
        m_escMem[i] = 1'b1;
      end
    end
    n = 0;
    budget = 0;
    while (n < count && budget < 100) begin
      @(negedge clock);
      budget++;
      if (m_ready != '0) n++;
    end
    check("burst_done", 64'(n), 64'(count));
    m_escMem = '0;
    @(posedge clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int edges, r0;
    bit seen;
    logic [31:0] exp_rd;

    vecs[0] = '{0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0};
    vecs[2] = '{2, 1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678};
    vecs[3] = '{0, 1'b1, 1'b0, 32'h0000_0024, 32'h0};
    vecs[4] = '{1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5};
    vecs[5] = '{2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0};
    vecs[6] = '{0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D};
    vecs[7] = '{1, 1'b1, 1'b0, 32'h0000_0020, 32'h0};
    vecs[8] = '{2, 1'b1, 1'b0, 32'h0000_0300, 32'h0};

    reset = 1'b1;
    m_lerMem = '0;
    m_escMem = '0;
    m_endereco = '0;
    m_indata = '0;

    // Reset for two cycles: every output must be zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_endereco", 64'(endereco), 64'd0);
    check("rst_indata", 64'(indata), 64'd0);
    check("rst_lerMem", 64'(lerMem), 64'd0);
    check("rst_escMem", 64'(escMem), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("idle_no_strobe", 64'(strobes), 64'd0);

    for (int v = 0; v < 9; v++) begin
      do_txn(vecs[v].m, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].data);
    end

    // All three masters requesting continuously.
    run_burst(3'b111, 6);

    // m2 raises its request in m1's DONE cycle and is served in the following IDLE.
    void'(push_exp(1, 1'b1, 32'h200, 32'h2222_0000));
    m_endereco[1*AW +: AW] = 32'h200;
    m_indata[1*DW +: DW]   = 32'h2222_0000;
    m_escMem[1] = 1'b1;
    wait_ready(1, 20, edges, seen);
    check("done_arrival_first", 64'(seen), 64'd1);
    m_escMem[1] = 1'b0;
    void'(push_exp(2, 1'b1, 32'h204, 32'h3333_0000));
    m_endereco[2*AW +: AW] = 32'h204;
    m_indata[2*DW +: DW]   = 32'h3333_0000;
    m_escMem[2] = 1'b1;
    wait_ready(2, 20, edges, seen);
    check("done_arrival_seen", 64'(seen), 64'd1);
    check("done_arrival_latency", 64'(edges), 64'd3);
    m_escMem[2] = 1'b0;
    @(posedge clock); #1;

    // m0 drops its read after the grant; the transaction still completes.
    exp_rd = push_exp(0, 1'b0, 32'h10, 32'h0);
    m_endereco[0*AW +: AW] = 32'h10;
    m_lerMem[0] = 1'b1;
    @(posedge clock); #1;
    m_lerMem[0] = 1'b0;
    wait_ready(0, 20, edges, seen);
    check("drop_still_ready", 64'(seen), 64'd1);
    check("drop_latency", 64'(edges), 64'(ML + 1));
    last_rd = exp_rd;
    @(posedge clock); #1;

    // Reset while m1's read is in WAIT: abandoned, with no m_ready pulse.
    void'(push_exp(1, 1'b0, 32'h24, 32'h0));
    m_endereco[1*AW +: AW] = 32'h24;
    m_lerMem[1] = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    m_lerMem[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_m_ready", 64'(m_ready), 64'd0);
    check("abort_lerMem", 64'(lerMem), 64'd0);
    check("abort_endereco", 64'(endereco), 64'd0);
    check("abort_m_rdata", 64'(m_rdata), 64'd0);
    sb.delete();
    rr_model = 0;
    last_rd = '0;
    r0 = ready_total;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("abort_no_ready", 64'(ready_total - r0), 64'd0);

    // After reset, master 0 is granted ahead of master 2.
    run_burst(3'b101, 2);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
